// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two pipeline stages.
// master drives the stage inputs, slave is the stage itself.
interface pipe_stage_skid_if #(
    parameter int PC_W   = 32,
    parameter int CTRL_W = 32,
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_pc, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_pc, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_pc, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_pc, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with 2-entry skid, flush-to-bubble
// and a saturating stall-cycle counter. All outputs are flops.
module pipe_stage_skid #(
    parameter int                PC_W        = 32,
    parameter int                CTRL_W      = 32,
    parameter int                DATA_W      = 64,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int                CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pipe_stage_skid_if.slave bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [PC_W-1:0]   m_pc_q, m_pc_n;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_n;
    logic [DATA_W-1:0] m_data_q, m_data_n;
    logic [PC_W-1:0]   s_pc_q, s_pc_n;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_n;
    logic [DATA_W-1:0] s_data_q, s_data_n;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [1:0]        occ_q;
    logic [CNT_W-1:0]  stall_q;
    logic              accept;
    logic              send;

    assign accept = bus.in_valid & in_ready_q;
    assign send   = out_valid_q & bus.out_ready;

    // Next-state and slot moves; flush wins over send and accept.
    always_comb begin
        state_n  = state_q;
        m_pc_n   = m_pc_q;
        m_ctrl_n = m_ctrl_q;
        m_data_n = m_data_q;
        s_pc_n   = s_pc_q;
        s_ctrl_n = s_ctrl_q;
        s_data_n = s_data_q;
        if (flush) begin
            state_n  = EMPTY;
            m_ctrl_n = BUBBLE_CTRL;
            s_pc_n   = '0;
            s_ctrl_n = BUBBLE_CTRL;
            s_data_n = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_n  = ONE;
                        m_pc_n   = bus.in_pc;
                        m_ctrl_n = bus.in_ctrl;
                        m_data_n = bus.in_data;
                    end
                end
                ONE: begin
                    if (send && accept) begin
                        m_pc_n   = bus.in_pc;
                        m_ctrl_n = bus.in_ctrl;
                        m_data_n = bus.in_data;
                    end else if (send) begin
                        state_n  = EMPTY;
                        m_ctrl_n = BUBBLE_CTRL;
                    end else if (accept) begin
                        state_n  = FULL;
                        s_pc_n   = bus.in_pc;
                        s_ctrl_n = bus.in_ctrl;
                        s_data_n = bus.in_data;
                    end
                end
                FULL: begin
                    if (send) begin
                        state_n  = ONE;
                        m_pc_n   = s_pc_q;
                        m_ctrl_n = s_ctrl_q;
                        m_data_n = s_data_q;
                        s_pc_n   = '0;
                        s_ctrl_n = BUBBLE_CTRL;
                        s_data_n = '0;
                    end
                end
                default: begin
                    state_n  = EMPTY;
                    m_ctrl_n = BUBBLE_CTRL;
                end
            endcase
        end
    end

    // Slot, state and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            m_pc_q      <= '0;
            m_ctrl_q    <= BUBBLE_CTRL;
            m_data_q    <= '0;
            s_pc_q      <= '0;
            s_ctrl_q    <= BUBBLE_CTRL;
            s_data_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_n;
            m_pc_q      <= m_pc_n;
            m_ctrl_q    <= m_ctrl_n;
            m_data_q    <= m_data_n;
            s_pc_q      <= s_pc_n;
            s_ctrl_q    <= s_ctrl_n;
            s_data_q    <= s_data_n;
            out_valid_q <= (state_n != EMPTY);
            in_ready_q  <= (state_n != FULL);
            occ_q       <= (state_n == FULL) ? 2'd2 :
                           (state_n == ONE)  ? 2'd1 : 2'd0;
        end
    end

    // Saturating count of cycles a presented beat was back-pressured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid_q && !bus.out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = m_pc_q;
    assign bus.out_ctrl  = m_ctrl_q;
    assign bus.out_data  = m_data_q;
    assign occupancy     = occ_q;
    assign stall_cycles  = stall_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic,
// two DUTs (16-bit and 4-bit stall counters) against a queue model.
module tb_pipe_stage_skid;
    localparam logic [31:0] BUB = 32'hB0B0_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_ctrl = '0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic [1:0]  occ_a, occ_b;
    logic [15:0] stall_a;
    logic [3:0]  stall_b;

    pipe_stage_skid_if #(.PC_W(32), .CTRL_W(32), .DATA_W(64)) bus_a ();
    pipe_stage_skid_if #(.PC_W(32), .CTRL_W(32), .DATA_W(64)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_pc     = in_pc;
    assign bus_a.in_ctrl   = in_ctrl;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_pc     = in_pc;
    assign bus_b.in_ctrl   = in_ctrl;
    assign bus_b.in_data   = in_data;
    assign bus_b.out_ready = out_ready;

    pipe_stage_skid #(
        .PC_W(32), .CTRL_W(32), .DATA_W(64),
        .BUBBLE_CTRL(BUB), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a),
        .occupancy(occ_a), .stall_cycles(stall_a)
    );

    pipe_stage_skid #(
        .PC_W(32), .CTRL_W(32), .DATA_W(64),
        .BUBBLE_CTRL(BUB), .CNT_W(4)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b),
        .occupancy(occ_b), .stall_cycles(stall_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of at most two beats.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ctrl;
        logic [63:0] data;
    } beat_t;

    beat_t       q[$];
    logic [31:0] held_pc = '0;
    logic [63:0] held_data = '0;
    longint      m_stall = 0;

    always @(posedge clk) begin : model
        int sz;
        bit snd, acc;
        beat_t b;
        if (!rst_n) begin
            q.delete();
            held_pc   = '0;
            held_data = '0;
            m_stall   = 0;
        end else begin
            sz  = q.size();
            snd = (sz > 0) && out_ready;
            acc = in_valid && (sz < 2);
            if (sz > 0 && !out_ready) m_stall++;
            if (sz > 0) begin
                held_pc   = q[0].pc;
                held_data = q[0].data;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (snd) void'(q.pop_front());
                if (acc) begin
                    b.pc   = in_pc;
                    b.ctrl = in_ctrl;
                    b.data = in_data;
                    q.push_back(b);
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin : compare
        logic        ev;
        logic [31:0] epc, ectl;
        logic [63:0] edat;
        longint      es16, es4;
        if (chk_en) begin
            ev   = (q.size() > 0);
            epc  = ev ? q[0].pc : held_pc;
            ectl = ev ? q[0].ctrl : BUB;
            edat = ev ? q[0].data : held_data;
            es16 = (m_stall > 65535) ? 65535 : m_stall;
            es4  = (m_stall > 15) ? 15 : m_stall;
            cmp("a.out_valid", 64'(bus_a.out_valid), 64'(ev));
            cmp("a.in_ready", 64'(bus_a.in_ready), 64'(q.size() < 2));
            cmp("a.occupancy", 64'(occ_a), 64'(q.size()));
            cmp("a.out_ctrl", 64'(bus_a.out_ctrl), 64'(ectl));
            cmp("a.out_pc", 64'(bus_a.out_pc), 64'(epc));
            cmp("a.out_data", bus_a.out_data, edat);
            cmp("a.stall", 64'(stall_a), 64'(es16));
            cmp("b.out_valid", 64'(bus_b.out_valid), 64'(ev));
            cmp("b.occupancy", 64'(occ_b), 64'(q.size()));
            cmp("b.out_ctrl", 64'(bus_b.out_ctrl), 64'(ectl));
            cmp("b.out_pc", 64'(bus_b.out_pc), 64'(epc));
            cmp("b.stall", 64'(stall_b), 64'(es4));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_ctrl  = pc ^ 32'h5A5A_0000;
        in_data  = {pc, ~pc};
    endtask

    logic [31:0] seq;

    initial begin
        // Reset with upstream trying to push.
        rst_n = 1'b0;
        put(32'hAA);
        out_ready = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        cmp("rst.out_valid", 64'(bus_a.out_valid), 64'd0);
        cmp("rst.in_ready", 64'(bus_a.in_ready), 64'd1);
        cmp("rst.occ", 64'(occ_a), 64'd0);
        cmp("rst.out_ctrl", 64'(bus_a.out_ctrl), 64'(BUB));
        cmp("rst.stall", 64'(stall_a), 64'd0);
        cmp("rst.out_pc", 64'(bus_a.out_pc), 64'd0);

        // Streaming at one beat per cycle.
        rst_n = 1'b1;
        put(32'h100);
        cyc();
        cmp("stream.pc0", 64'(bus_a.out_pc), 64'h100);
        cmp("stream.occ0", 64'(occ_a), 64'd1);
        put(32'h104);
        cyc();
        cmp("stream.pc1", 64'(bus_a.out_pc), 64'h104);
        put(32'h108);
        cyc();
        cmp("stream.pc2", 64'(bus_a.out_pc), 64'h108);
        cmp("stream.occ2", 64'(occ_a), 64'd1);
        in_valid = 1'b0;
        cyc();
        cmp("stream.drain", 64'(bus_a.out_valid), 64'd0);
        cmp("stream.hold_pc", 64'(bus_a.out_pc), 64'h108);

        // Skid fill under back-pressure, then drain in order.
        out_ready = 1'b0;
        put(32'h200);
        cyc();
        put(32'h204);
        cyc();
        cmp("skid.occ", 64'(occ_a), 64'd2);
        cmp("skid.in_ready", 64'(bus_a.in_ready), 64'd0);
        put(32'h208);
        cyc();
        cyc();
        cmp("skid.head", 64'(bus_a.out_pc), 64'h200);
        cmp("skid.stall", 64'(stall_a), 64'd3);
        out_ready = 1'b1;
        cyc();
        cmp("skid.pc1", 64'(bus_a.out_pc), 64'h204);
        cyc();
        cmp("skid.pc2", 64'(bus_a.out_pc), 64'h208);
        in_valid = 1'b0;
        cyc();
        cmp("skid.empty", 64'(occ_a), 64'd0);
        cmp("skid.stall_end", 64'(stall_a), 64'd3);

        // Flush a full stage with a beat offered in the same cycle.
        out_ready = 1'b0;
        put(32'h300);
        cyc();
        put(32'h304);
        cyc();
        flush = 1'b1;
        put(32'h308);
        cyc();
        cmp("flush.occ", 64'(occ_a), 64'd0);
        cmp("flush.out_valid", 64'(bus_a.out_valid), 64'd0);
        cmp("flush.out_ctrl", 64'(bus_a.out_ctrl), 64'(BUB));
        cmp("flush.hold_pc", 64'(bus_a.out_pc), 64'h300);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            cmp("flush.no_308", 64'(bus_a.out_valid), 64'd0);
        end

        // Saturate the 4-bit counter.
        out_ready = 1'b0;
        put(32'h400);
        cyc();
        in_valid = 1'b0;
        repeat (20) cyc();
        cmp("sat.15", 64'(stall_b), 64'd15);
        repeat (5) cyc();
        cmp("sat.stays", 64'(stall_b), 64'd15);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cmp("sat.flush_keeps", 64'(stall_b), 64'd15);

        // Random traffic with occasional flush and reset.
        seq = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 99) < 5);
            out_ready = ($urandom_range(0, 99) < 60);
            in_valid  = ($urandom_range(0, 99) < 65);
            in_pc     = seq;
            in_ctrl   = $urandom;
            in_data   = {$urandom, $urandom};
            if (in_valid) seq = seq + 32'd4;
            cyc();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        rst_n = 1'b1;
        repeat (3) cyc();

        @(posedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
